// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit
//  Description : Instruction fetch stage. Issues at most one outstanding word
//                read to instruction memory, tags it with its PC, and buffers
//                returned instructions in a 2-entry FIFO for decode. A flush
//                empties the buffer and drops any response still in flight.
//                Optional macro FETCH_ERR_EN adds a per-entry bus-error flag
//                (i_mem_err / o_instr_err) and stops fetching after an error
//                entry until flush or reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter int WIDTH = 32,
    parameter int ILEN  = 32
) (
    input  logic             clk,
    input  logic             rst,            // asynchronous, active-low
    input  logic [WIDTH-1:0] i_pc,
    output logic             o_pc_en,
    output logic             o_mem_req,
    output logic [WIDTH-1:0] o_mem_addr,
    input  logic             i_mem_gnt,
    input  logic             i_mem_rvalid,
    input  logic [ILEN-1:0]  i_mem_rdata,
`ifdef FETCH_ERR_EN
    input  logic             i_mem_err,
    output logic             o_instr_err,
`endif
    output logic             o_instr_valid,
    output logic [ILEN-1:0]  o_instr,
    output logic [WIDTH-1:0] o_instr_pc,
    input  logic             i_instr_ready,
    input  logic             i_flush
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_tag;

    logic [ILEN-1:0]  r_fifo_instr [2];
    logic [WIDTH-1:0] r_fifo_pc    [2];
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [1:0]       r_count;

    logic             w_req;
    logic             w_push;
    logic             w_pop;
    logic             w_latch_tag;
    logic             w_stall;

`ifdef FETCH_ERR_EN
    logic [1:0]       r_fifo_err;
    logic             r_err_hold;

    assign w_stall     = r_err_hold;
    assign o_instr_err = r_fifo_err[r_rd_ptr];
`else
    assign w_stall     = 1'b0;
`endif

    // Issue only when the FIFO can absorb the response; rst gates the request
    // so nothing is asked of memory while reset is held.
    assign o_mem_req     = w_req;
    assign o_mem_addr    = i_pc;
    assign o_pc_en       = w_req & i_mem_gnt;
    assign o_instr_valid = (r_count != 2'd0);
    assign o_instr       = r_fifo_instr[r_rd_ptr];
    assign o_instr_pc    = r_fifo_pc[r_rd_ptr];
    assign w_pop         = o_instr_valid & i_instr_ready;

    // Next-state and request/push decode
    always_comb begin
        w_state_nxt = r_state;
        w_req       = 1'b0;
        w_push      = 1'b0;
        w_latch_tag = 1'b0;
        case (r_state)
            S_REQ: begin
                w_req = rst & (r_count < 2'd2) & ~i_flush & ~w_stall;
                if (w_req && i_mem_gnt) begin
                    w_latch_tag = 1'b1;
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (i_mem_rvalid) begin
                    w_push      = ~i_flush;
                    w_state_nxt = S_REQ;
                end else if (i_flush) begin
                    w_state_nxt = S_DROP;
                end
            end
            S_DROP: begin
                // Response to a flushed request is swallowed whatever i_flush says
                if (i_mem_rvalid) begin
                    w_state_nxt = S_REQ;
                end
            end
            default: w_state_nxt = S_REQ;
        endcase
    end

    // State register and in-flight PC tag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_REQ;
            r_tag   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_latch_tag) begin
                r_tag <= i_pc;
            end
        end
    end

    // Two-entry instruction FIFO; flush overrides push and pop
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 2; i++) begin
                r_fifo_instr[i] <= '0;
                r_fifo_pc[i]    <= '0;
            end
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_fifo_instr[r_wr_ptr] <= i_mem_rdata;
                r_fifo_pc[r_wr_ptr]    <= r_tag;
            end
            if (i_flush) begin
                r_wr_ptr <= 1'b0;
                r_rd_ptr <= 1'b0;
                r_count  <= 2'd0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= ~r_wr_ptr;
                end
                if (w_pop) begin
                    r_rd_ptr <= ~r_rd_ptr;
                end
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + 2'd1;
                    2'b01:   r_count <= r_count - 2'd1;
                    default: r_count <= r_count;
                endcase
            end
        end
    end

`ifdef FETCH_ERR_EN
    // Per-entry error flag and the fetch hold that follows an error
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fifo_err <= 2'b00;
            r_err_hold <= 1'b0;
        end else begin
            if (w_push) begin
                r_fifo_err[r_wr_ptr] <= i_mem_err;
            end
            if (i_flush) begin
                r_err_hold <= 1'b0;
            end else if (w_push && i_mem_err) begin
                r_err_hold <= 1'b1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_unit
//  Description : Scoreboard bench for fetch_unit. A behavioural memory with a
//                programmable response delay and a bench-side PC drive the
//                DUT; directed scenarios push hand-computed instructions into
//                a queue that a negedge monitor pops on every handshake.
//                Define FETCH_ERR_EN to also exercise the error-entry path.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] i_pc = '0;
    logic        o_pc_en;
    logic        o_mem_req;
    logic [31:0] o_mem_addr;
    logic        i_mem_gnt = 1'b1;
    logic        i_mem_rvalid = 1'b0;
    logic [31:0] i_mem_rdata = '0;
    logic        o_instr_valid;
    logic [31:0] o_instr;
    logic [31:0] o_instr_pc;
    logic        i_instr_ready = 1'b1;
    logic        i_flush = 1'b0;
`ifdef FETCH_ERR_EN
    logic        i_mem_err = 1'b0;
    logic        o_instr_err;
    logic [31:0] err_addr = 32'hFFFF_FFFF;
`endif

    int          checks = 0;
    int          errors = 0;
    exp_t        sbq[$];

    // Memory / PC model state
    int          resp_dly = 1;
    int          resp_cnt = 0;
    logic [31:0] resp_addr = '0;
    logic        gnt_seen = 1'b0;
    logic [31:0] gnt_addr = '0;
    logic        pcen_seen = 1'b0;
    int          pcen_cnt = 0;
    logic [31:0] pc_start = '0;

    fetch_unit #(.WIDTH(32), .ILEN(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_pc         (i_pc),
        .o_pc_en      (o_pc_en),
        .o_mem_req    (o_mem_req),
        .o_mem_addr   (o_mem_addr),
        .i_mem_gnt    (i_mem_gnt),
        .i_mem_rvalid (i_mem_rvalid),
        .i_mem_rdata  (i_mem_rdata),
`ifdef FETCH_ERR_EN
        .i_mem_err    (i_mem_err),
        .o_instr_err  (o_instr_err),
`endif
        .o_instr_valid(o_instr_valid),
        .o_instr      (o_instr),
        .o_instr_pc   (o_instr_pc),
        .i_instr_ready(i_instr_ready),
        .i_flush      (i_flush)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a == 32'h10) ? 32'hDEAD_BEEF : (32'h13 | (a << 8));
    endfunction

    // Observe grants and PC strobes mid-cycle
    always @(negedge clk) begin
        gnt_seen  = rst && o_mem_req && i_mem_gnt;
        gnt_addr  = o_mem_addr;
        pcen_seen = rst && o_pc_en;
        if (pcen_seen) pcen_cnt++;
    end

    // Drive PC and memory response just after each rising edge
    always @(posedge clk) begin
        #1;
        i_mem_rvalid = 1'b0;
        i_mem_rdata  = '0;
`ifdef FETCH_ERR_EN
        i_mem_err    = 1'b0;
`endif
        if (!rst) i_pc = pc_start;
        else if (pcen_seen) i_pc = i_pc + 32'd1;
        if (gnt_seen) begin
            resp_cnt  = resp_dly;
            resp_addr = gnt_addr;
        end
        if (resp_cnt > 0) begin
            resp_cnt--;
            if (resp_cnt == 0) begin
                i_mem_rvalid = 1'b1;
                i_mem_rdata  = mem_word(resp_addr);
`ifdef FETCH_ERR_EN
                i_mem_err    = (resp_addr == err_addr);
`endif
            end
        end
    end

    // Scoreboard monitor: compare every consumed instruction
    always @(negedge clk) begin
        if (rst && o_instr_valid && i_instr_ready) begin
            automatic exp_t e;
            automatic logic got_err = 1'b0;
`ifdef FETCH_ERR_EN
            got_err = o_instr_err;
`endif
            checks++;
            if (sbq.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: got pc=%h instr=%h, expected no instruction", o_instr_pc, o_instr);
            end else begin
                e = sbq.pop_front();
`ifndef FETCH_ERR_EN
                e.err = 1'b0;
`endif
                if (o_instr_pc !== e.pc || o_instr !== e.instr || got_err !== e.err) begin
                    errors++;
                    $display("FAIL sb_entry: got pc=%h instr=%h err=%b, expected pc=%h instr=%h err=%b",
                             o_instr_pc, o_instr, got_err, e.pc, e.instr, e.err);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    task automatic expect_instr(input logic [31:0] pc, input logic [31:0] instr, input logic err);
        exp_t e;
        e.pc    = pc;
        e.instr = instr;
        e.err   = err;
        sbq.push_back(e);
    endtask

    // Assert reset for two cycles, check reset outputs, release at cycle 0
    task automatic do_reset(input logic [31:0] pc);
        tick();
        rst      = 1'b0;
        pc_start = pc;
        i_flush  = 1'b0;
        sample();
        chk("rst_mem_req", {31'd0, o_mem_req}, 32'd0);
        chk("rst_pc_en", {31'd0, o_pc_en}, 32'd0);
        chk("rst_valid", {31'd0, o_instr_valid}, 32'd0);
        chk("rst_instr", o_instr, 32'd0);
        chk("rst_instr_pc", o_instr_pc, 32'd0);
`ifdef FETCH_ERR_EN
        chk("rst_instr_err", {31'd0, o_instr_err}, 32'd0);
`endif
        tick();
        sample();
        tick();
        rst = 1'b1;
    endtask

    // Stop granting, consume everything, expect the scoreboard to empty
    task automatic drain();
        tick();
        i_mem_gnt     = 1'b0;
        i_instr_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            sample();
            if (sbq.size() == 0) break;
            tick();
        end
        chk("sb_drained", 32'(sbq.size()), 32'd0);
        tick();
        sample();
        chk("drain_empty", {31'd0, o_instr_valid}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no end of test, expected completion");
        $fatal(1);
    end

    initial begin
        int base;

        // ---- Back-to-back fetch, zero-wait memory ----
        i_mem_gnt = 1'b1; i_instr_ready = 1'b1; resp_dly = 1;
        do_reset(32'h0);
        base = pcen_cnt;
        expect_instr(32'h0, 32'h0000_0013, 1'b0);
        expect_instr(32'h1, 32'h0000_0113, 1'b0);
        expect_instr(32'h2, 32'h0000_0213, 1'b0);
        sample();
        chk("a_c0_req", {31'd0, o_mem_req}, 32'd1);
        chk("a_c0_pc_en", {31'd0, o_pc_en}, 32'd1);
        chk("a_c0_addr", o_mem_addr, 32'h0);
        tick(); sample();
        chk("a_c1_pc_en", {31'd0, o_pc_en}, 32'd0);
        chk("a_c1_valid", {31'd0, o_instr_valid}, 32'd0);
        tick(); sample();
        chk("a_c2_valid", {31'd0, o_instr_valid}, 32'd1);
        chk("a_c2_instr_pc", o_instr_pc, 32'h0);
        chk("a_c2_pc_en", {31'd0, o_pc_en}, 32'd1);
        tick(); sample();
        chk("a_c3_pc_en", {31'd0, o_pc_en}, 32'd0);
        tick(); sample();
        chk("a_c4_pc_en", {31'd0, o_pc_en}, 32'd1);
        chk("a_c4_addr", o_mem_addr, 32'h2);
        drain();

        // ---- Decode stalled: FIFO fills with pc 0 and 1 ----
        i_mem_gnt = 1'b1; i_instr_ready = 1'b0; resp_dly = 1;
        do_reset(32'h0);
        base = pcen_cnt;
        expect_instr(32'h0, 32'h0000_0013, 1'b0);
        expect_instr(32'h1, 32'h0000_0113, 1'b0);
        expect_instr(32'h2, 32'h0000_0213, 1'b0);
        sample();
        for (int c = 1; c <= 8; c++) begin
            tick(); sample();
        end
        chk("b_full_req", {31'd0, o_mem_req}, 32'd0);
        chk("b_full_valid", {31'd0, o_instr_valid}, 32'd1);
        chk("b_full_head", o_instr_pc, 32'h0);
        chk("b_pc_en_count", 32'(pcen_cnt - base), 32'd2);

        // ---- One-cycle ready on a full FIFO ----
        tick(); i_instr_ready = 1'b1;
        sample();
        tick(); i_instr_ready = 1'b0;
        sample();
        chk("c_head_pc1", o_instr_pc, 32'h1);
        chk("c_new_req", {31'd0, o_mem_req}, 32'd1);
        chk("c_new_pc_en", {31'd0, o_pc_en}, 32'd1);
        chk("c_new_addr", o_mem_addr, 32'h2);
        tick(); sample();
        tick(); sample();
        chk("c_refull_req", {31'd0, o_mem_req}, 32'd0);
        chk("c_refull_head", o_instr_pc, 32'h1);
        drain();

        // ---- Flush while waiting, late response dropped ----
        i_mem_gnt = 1'b1; i_instr_ready = 1'b1; resp_dly = 2;
        do_reset(32'h10);
        expect_instr(32'h11, 32'h0000_1113, 1'b0);
        sample();
        chk("d_c0_addr", o_mem_addr, 32'h10);
        chk("d_c0_pc_en", {31'd0, o_pc_en}, 32'd1);
        tick(); i_flush = 1'b1;
        sample();
        chk("d_flush_req", {31'd0, o_mem_req}, 32'd0);
        tick(); i_flush = 1'b0;
        sample();
        chk("d_drop_req", {31'd0, o_mem_req}, 32'd0);
        chk("d_drop_valid", {31'd0, o_instr_valid}, 32'd0);
        tick(); sample();
        chk("d_resume_valid", {31'd0, o_instr_valid}, 32'd0);
        chk("d_resume_req", {31'd0, o_mem_req}, 32'd1);
        chk("d_resume_addr", o_mem_addr, 32'h11);
        drain();

        // ---- Simultaneous push and pop at count 1 ----
        i_mem_gnt = 1'b1; i_instr_ready = 1'b0; resp_dly = 1;
        do_reset(32'h4);
        expect_instr(32'h4, 32'h0000_0413, 1'b0);
        expect_instr(32'h5, 32'h0000_0513, 1'b0);
        expect_instr(32'h6, 32'h0000_0613, 1'b0);
        sample();
        tick(); sample();
        tick(); sample();
        chk("e_c2_head", o_instr_pc, 32'h4);
        chk("e_c2_pc_en", {31'd0, o_pc_en}, 32'd1);
        tick(); i_instr_ready = 1'b1;
        sample();
        chk("e_c3_head", o_instr_pc, 32'h4);
        tick(); i_instr_ready = 1'b0;
        sample();
        chk("e_c4_valid", {31'd0, o_instr_valid}, 32'd1);
        chk("e_c4_head", o_instr_pc, 32'h5);
        chk("e_c4_req", {31'd0, o_mem_req}, 32'd1);
        chk("e_c4_addr", o_mem_addr, 32'h6);
        drain();

        // ---- Reset mid-request, stale response ignored ----
        i_mem_gnt = 1'b1; i_instr_ready = 1'b1; resp_dly = 3;
        do_reset(32'h8);
        expect_instr(32'h8, 32'h0000_0813, 1'b0);
        sample();
        chk("f_c0_pc_en", {31'd0, o_pc_en}, 32'd1);
        tick(); rst = 1'b0; i_mem_gnt = 1'b0;
        sample();
        chk("f_rst_req", {31'd0, o_mem_req}, 32'd0);
        tick(); rst = 1'b1;
        sample();
        chk("f_rel_req", {31'd0, o_mem_req}, 32'd1);
        chk("f_rel_addr", o_mem_addr, 32'h8);
        for (int c = 3; c <= 5; c++) begin
            tick(); sample();
            chk("f_stale_valid", {31'd0, o_instr_valid}, 32'd0);
        end
        tick(); i_mem_gnt = 1'b1;
        sample();
        chk("f_regrant_pc_en", {31'd0, o_pc_en}, 32'd1);
        drain();

`ifdef FETCH_ERR_EN
        // ---- Bus error on pc 3 halts fetch until flush ----
        i_mem_gnt = 1'b1; i_instr_ready = 1'b1; resp_dly = 1; err_addr = 32'h3;
        do_reset(32'h0);
        base = pcen_cnt;
        expect_instr(32'h0, 32'h0000_0013, 1'b0);
        expect_instr(32'h1, 32'h0000_0113, 1'b0);
        expect_instr(32'h2, 32'h0000_0213, 1'b0);
        expect_instr(32'h3, 32'h0000_0313, 1'b1);
        sample();
        for (int c = 1; c <= 8; c++) begin
            tick(); sample();
        end
        chk("g_err_flag", {31'd0, o_instr_err}, 32'd1);
        chk("g_err_pc", o_instr_pc, 32'h3);
        chk("g_err_req", {31'd0, o_mem_req}, 32'd0);
        for (int c = 9; c <= 11; c++) begin
            tick(); sample();
            chk("g_hold_req", {31'd0, o_mem_req}, 32'd0);
        end
        chk("g_pc_en_count", 32'(pcen_cnt - base), 32'd4);
        tick(); i_flush = 1'b1;
        sample();
        tick(); i_flush = 1'b0; i_mem_gnt = 1'b0; err_addr = 32'hFFFF_FFFF;
        sample();
        chk("g_post_flush_req", {31'd0, o_mem_req}, 32'd1);
        drain();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
